// File: rtl/sensor_gen_pkg.sv
// Shared types and constants for the sensor timing generator.
package sensor_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRAME_HIDE,
    ST_FVAL_HEAD,
    ST_LINE_ACTIVE,
    ST_LINE_HIDE,
    ST_FVAL_TAIL
  } gen_state_e;

  typedef enum logic [1:0] {
    PAT_COLUMN = 2'b00,
    PAT_LINE   = 2'b01,
    PAT_FRAME  = 2'b10,
    PAT_LFSR   = 2'b11
  } pattern_e;

  localparam logic [15:0] LFSR_SEED       = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, shift-left Fibonacci form: bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS       = 16'hB400;
  localparam logic [15:0] ALIGN_HEAD_TAIL = 16'd3;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [15:0] clamp_min1(input logic [15:0] v);
    return (v == '0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/sensor_pattern_lfsr.sv
// Free-running pattern LFSR, steps only when told to.
module sensor_pattern_lfsr
  import sensor_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        advance,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = advance ? lfsr_step(state_q) : state_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= LFSR_SEED;
    else          state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/sensor_timing_gen.sv
// Parallel-sensor fval/lval/pixel stream generator with frame-boundary latching.
module sensor_timing_gen
  import sensor_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 10,
  parameter int unsigned REG_WD          = 32,
  parameter string       FVAL_LVAL_ALIGN = "TRUE"
) (
  input  logic                  clk_sensor_pix,
  input  logic                  reset_sensor_n,
  input  logic                  i_gen_en,
  input  logic [REG_WD-1:0]     iv_width,
  input  logic [REG_WD-1:0]     iv_height,
  input  logic [REG_WD-1:0]     iv_line_hide,
  input  logic [REG_WD-1:0]     iv_frame_hide,
  input  logic [REG_WD-1:0]     iv_head,
  input  logic [REG_WD-1:0]     iv_tail,
  input  logic [1:0]            iv_pattern_sel,
  output logic                  o_fval,
  output logic                  o_lval,
  output logic [DATA_WIDTH-1:0] ov_pix_data,
  output logic                  o_frame_done,
  output logic [15:0]           ov_frame_cnt
);

  localparam bit ALIGN_FIXED = (FVAL_LVAL_ALIGN == "TRUE");

  gen_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] line_q, line_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] frame_start_q, frame_start_d;
  logic [15:0] width_q, width_d, height_q, height_d;
  logic [15:0] lhide_q, lhide_d, fhide_q, fhide_d;
  logic [15:0] head_q, head_d, tail_q, tail_d;
  pattern_e    pat_q, pat_d;
  logic        fval_q, fval_d, lval_q, lval_d, done_q, done_d;
  logic [DATA_WIDTH-1:0] pix_q, pix_d;
  logic        latch;
  logic        advance;
  logic [15:0] lfsr_state;
  logic [15:0] pix_src;

  if (REG_WD > 16) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^{iv_width[REG_WD-1:16], iv_height[REG_WD-1:16],
                         iv_line_hide[REG_WD-1:16], iv_frame_hide[REG_WD-1:16],
                         iv_head[REG_WD-1:16], iv_tail[REG_WD-1:16]};
  end

  assign advance = (state_q == ST_LINE_ACTIVE);

  sensor_pattern_lfsr u_lfsr (
    .clk     (clk_sensor_pix),
    .reset_n (reset_sensor_n),
    .advance (advance),
    .state   (lfsr_state)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    frame_cnt_d = frame_cnt_q;
    latch       = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_gen_en) begin
          state_d = ST_FRAME_HIDE;
          cnt_d   = '0;
          latch   = 1'b1;
        end
      end
      ST_FRAME_HIDE: begin
        if (cnt_q == fhide_q - 16'd1) begin
          state_d = ST_FVAL_HEAD;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 16'd1;
      end
      ST_FVAL_HEAD: begin
        if (cnt_q == head_q - 16'd1) begin
          state_d = ST_LINE_ACTIVE;
          cnt_d   = '0;
          line_d  = '0;
        end else cnt_d = cnt_q + 16'd1;
      end
      ST_LINE_ACTIVE: begin
        if (cnt_q == width_q - 16'd1) begin
          cnt_d   = '0;
          state_d = (line_q == height_q - 16'd1) ? ST_FVAL_TAIL : ST_LINE_HIDE;
        end else cnt_d = cnt_q + 16'd1;
      end
      ST_LINE_HIDE: begin
        if (cnt_q == lhide_q - 16'd1) begin
          state_d = ST_LINE_ACTIVE;
          cnt_d   = '0;
          line_d  = line_q + 16'd1;
        end else cnt_d = cnt_q + 16'd1;
      end
      ST_FVAL_TAIL: begin
        if (cnt_q == tail_q - 16'd1) begin
          cnt_d       = '0;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (i_gen_en) begin
            state_d = ST_FRAME_HIDE;
            latch   = 1'b1;
          end else state_d = ST_IDLE;
        end else cnt_d = cnt_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so all registered outputs move on one edge.
  always_comb begin
    width_d       = latch ? clamp_min1(iv_width[15:0])      : width_q;
    height_d      = latch ? clamp_min1(iv_height[15:0])     : height_q;
    lhide_d       = latch ? clamp_min1(iv_line_hide[15:0])  : lhide_q;
    fhide_d       = latch ? clamp_min1(iv_frame_hide[15:0]) : fhide_q;
    head_d        = head_q;
    tail_d        = tail_q;
    if (latch) begin
      head_d = ALIGN_FIXED ? ALIGN_HEAD_TAIL : clamp_min1(iv_head[15:0]);
      tail_d = ALIGN_FIXED ? ALIGN_HEAD_TAIL : clamp_min1(iv_tail[15:0]);
    end
    pat_d         = latch ? pattern_e'(iv_pattern_sel) : pat_q;
    frame_start_d = latch ? frame_cnt_d : frame_start_q;

    fval_d = (state_d != ST_IDLE) && (state_d != ST_FRAME_HIDE);
    lval_d = (state_d == ST_LINE_ACTIVE);

    pix_src = '0;
    unique case (pat_q)
      PAT_COLUMN: pix_src = cnt_d;
      PAT_LINE:   pix_src = line_d;
      PAT_FRAME:  pix_src = frame_start_q;
      PAT_LFSR:   pix_src = advance ? lfsr_step(lfsr_state) : lfsr_state;
      default:    pix_src = '0;
    endcase
    pix_d = lval_d ? pix_src[DATA_WIDTH-1:0] : '0;
  end

  always_ff @(posedge clk_sensor_pix or negedge reset_sensor_n) begin
    if (!reset_sensor_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      line_q        <= '0;
      frame_cnt_q   <= '0;
      frame_start_q <= '0;
      width_q       <= 16'd1;
      height_q      <= 16'd1;
      lhide_q       <= 16'd1;
      fhide_q       <= 16'd1;
      head_q        <= 16'd1;
      tail_q        <= 16'd1;
      pat_q         <= PAT_COLUMN;
      fval_q        <= 1'b0;
      lval_q        <= 1'b0;
      done_q        <= 1'b0;
      pix_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      line_q        <= line_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_start_q <= frame_start_d;
      width_q       <= width_d;
      height_q      <= height_d;
      lhide_q       <= lhide_d;
      fhide_q       <= fhide_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      pat_q         <= pat_d;
      fval_q        <= fval_d;
      lval_q        <= lval_d;
      done_q        <= done_d;
      pix_q         <= pix_d;
    end
  end

  assign o_fval       = fval_q;
  assign o_lval       = lval_q;
  assign ov_pix_data  = pix_q;
  assign o_frame_done = done_q;
  assign ov_frame_cnt = frame_cnt_q;

endmodule
